// File: rtl/wb_write_buffer.sv
// Write-back buffer: queues register-file writes and drains them when the write port is free.
// Optional forwarding lookup is enabled by defining WB_WRITE_BUFFER_FORWARD_EN.
module wb_write_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_rd,
  input  logic [XLEN-1:0]            in_data,
  input  logic                       wb_busy,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  input  logic [4:0]                 q_addr_1,
  input  logic [4:0]                 q_addr_2,
  output logic                       hit_1,
  output logic                       hit_2,
  output logic [XLEN-1:0]            hit_data_1,
  output logic [XLEN-1:0]            hit_data_2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      rdMem_q   [DEPTH];
  logic [XLEN-1:0] dataMem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push;
  logic            pop;
  logic            notEmpty;

  // Ready depends only on occupancy, never on whether the head drains this cycle.
  assign notEmpty = (count_q != '0);
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready && (in_rd != 5'd0);
  assign pop      = notEmpty && !wb_busy;

  assign rf_we    = pop;
  assign rf_waddr = notEmpty ? rdMem_q[rdPtr_q]   : 5'd0;
  assign rf_wdata = notEmpty ? dataMem_q[rdPtr_q] : '0;
  assign count    = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + PW'(1);
    if (pop)  rdPtr_d = rdPtr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdMem_q[i]   <= 5'd0;
        dataMem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (push) begin
        rdMem_q[wrPtr_q]   <= in_rd;
        dataMem_q[wrPtr_q] <= in_data;
      end
    end
  end

`ifdef WB_WRITE_BUFFER_FORWARD_EN
  // Walk oldest to youngest so the last match found is the youngest pending write.
  always_comb begin
    hit_1      = 1'b0;
    hit_2      = 1'b0;
    hit_data_1 = '0;
    hit_data_2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        if ((q_addr_1 != 5'd0) && (rdMem_q[rdPtr_q + PW'(k)] == q_addr_1)) begin
          hit_1      = 1'b1;
          hit_data_1 = dataMem_q[rdPtr_q + PW'(k)];
        end
        if ((q_addr_2 != 5'd0) && (rdMem_q[rdPtr_q + PW'(k)] == q_addr_2)) begin
          hit_2      = 1'b1;
          hit_data_2 = dataMem_q[rdPtr_q + PW'(k)];
        end
      end
    end
  end
`else
  logic unusedQaddr;
  assign unusedQaddr = ^{q_addr_1, q_addr_2};
  assign hit_1      = 1'b0;
  assign hit_2      = 1'b0;
  assign hit_data_1 = '0;
  assign hit_data_2 = '0;
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// Scoreboard testbench for wb_write_buffer: accepted writes are queued and a
// monitor compares every register-file write against the queue head.
module tb_wb_write_buffer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef WB_WRITE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            rstn;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_data;
  logic            wb_busy;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [4:0]      q_addr_1;
  logic [4:0]      q_addr_2;
  logic            hit_1;
  logic            hit_2;
  logic [XLEN-1:0] hit_data_1;
  logic [XLEN-1:0] hit_data_2;
  logic [2:0]      count;

  int checks;
  int failures;
  logic [4+XLEN:0] expQ[$];

  wb_write_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wb_busy(wb_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr_1(q_addr_1), .q_addr_2(q_addr_2),
    .hit_1(hit_1), .hit_2(hit_2), .hit_data_1(hit_data_1), .hit_data_2(hit_data_2),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Holds the request until a cycle with in_ready, then records stored writes as expected.
  task automatic applyStimulus(input logic [4:0] rd, input logic [XLEN-1:0] data);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = data;
    for (int w = 0; w < 20 && !acc; w++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    if (acc && rd != 5'd0) expQ.push_back({1'b0, rd, data});
    #1;
    in_valid = 1'b0;
    in_rd    = 5'd0;
    in_data  = '0;
    checkOutput("accepted", 64'(acc), 64'd1);
  endtask

  task automatic waitDrain();
    for (int w = 0; w < 50 && count != 3'd0; w++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drainDone", 64'(count), 64'd0);
  endtask

  // Monitor: every register-file write must match the oldest expected entry.
  initial begin
    logic [4+XLEN:0] exp;
    forever begin
      @(negedge clk);
      if (rstn && rf_we) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedWrite actual=rd%0d/%0h expected=none", rf_waddr, rf_wdata);
        end else begin
          exp = expQ.pop_front();
          checkOutput("wbAddr", 64'(rf_waddr), 64'(exp[XLEN+4:XLEN]));
          checkOutput("wbData", 64'(rf_wdata), 64'(exp[XLEN-1:0]));
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_rd    = 5'd0;
    in_data  = '0;
    wb_busy  = 1'b0;
    q_addr_1 = 5'd10;
    q_addr_2 = 5'd3;

    #2;
    checkOutput("rstReady", 64'(in_ready), 64'd1);
    checkOutput("rstCount", 64'(count), 64'd0);
    checkOutput("rstWe", 64'(rf_we), 64'd0);
    checkOutput("rstWaddr", 64'(rf_waddr), 64'd0);
    checkOutput("rstWdata", 64'(rf_wdata), 64'd0);
    checkOutput("rstHit1", 64'(hit_1), 64'd0);
    checkOutput("rstHitData2", 64'(hit_data_2), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    $display("[TB] single write latency");
    applyStimulus(5'd10, 32'd21);
    checkOutput("lat1We", 64'(rf_we), 64'd1);
    checkOutput("lat1Addr", 64'(rf_waddr), 64'd10);
    checkOutput("lat1Data", 64'(rf_wdata), 64'd21);
    checkOutput("lat1Count", 64'(count), 64'd1);
    @(posedge clk); #1;
    checkOutput("lat1CountAfter", 64'(count), 64'd0);

    $display("[TB] stall until full then release");
    wb_busy = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(5'(i), 32'(100 + i));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("fullReady", 64'(in_ready), 64'd0);
    checkOutput("fullCount", 64'(count), 64'd4);
    checkOutput("fullWe", 64'(rf_we), 64'd0);
    wb_busy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("burstWe", 64'(rf_we), 64'd1);
      checkOutput("burstAddr", 64'(rf_waddr), 64'(i));
    end
    @(posedge clk); #1;
    checkOutput("burstCount", 64'(count), 64'd0);

    $display("[TB] forwarding youngest match");
    wb_busy = 1'b1;
    applyStimulus(5'd5, 32'd7);
    applyStimulus(5'd5, 32'd9);
    q_addr_1 = 5'd5;
    q_addr_2 = 5'd0;
    #1;
    checkOutput("fwdHit1", 64'(hit_1), 64'(FWD));
    checkOutput("fwdData1", 64'(hit_data_1), FWD ? 64'd9 : 64'd0);
    checkOutput("fwdHit2Zero", 64'(hit_2), 64'd0);
    checkOutput("fwdData2Zero", 64'(hit_data_2), 64'd0);
    q_addr_2 = 5'd6;
    in_valid = 1'b1;
    in_rd    = 5'd6;
    in_data  = 32'd55;
    #1;
    checkOutput("fwdNoSameCycle", 64'(hit_2), 64'd0);
    in_valid = 1'b0;
    in_rd    = 5'd0;
    in_data  = '0;
    q_addr_2 = 5'd5;
    #1;
    checkOutput("fwdHit2", 64'(hit_2), 64'(FWD));
    checkOutput("fwdData2", 64'(hit_data_2), FWD ? 64'd9 : 64'd0);
    wb_busy = 1'b0;
    waitDrain();
    checkOutput("fwdMissAfterDrain", 64'(hit_1), 64'd0);

    $display("[TB] zero destination not stored");
    applyStimulus(5'd0, 32'd123);
    checkOutput("rd0Count", 64'(count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rd0We", 64'(rf_we), 64'd0);

    $display("[TB] simultaneous push and drain at count 1");
    wb_busy = 1'b1;
    applyStimulus(5'd3, 32'd33);
    wb_busy = 1'b0;
    applyStimulus(5'd4, 32'd44);
    checkOutput("simCount1", 64'(count), 64'd1);
    waitDrain();

    $display("[TB] simultaneous push and drain at count 3 with wrap");
    wb_busy = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(5'(11 + i), 32'(200 + i));
    checkOutput("preSimCount3", 64'(count), 64'd3);
    wb_busy = 1'b0;
    applyStimulus(5'd14, 32'd214);
    checkOutput("simCount3", 64'(count), 64'd3);
    for (int i = 0; i < 10; i++) applyStimulus(5'(16 + i), 32'(1000 + i));
    checkOutput("wrapCount", 64'(count), 64'd3);
    waitDrain();

    $display("[TB] reset mid-operation");
    wb_busy = 1'b1;
    applyStimulus(5'd20, 32'd300);
    applyStimulus(5'd21, 32'd301);
    q_addr_1 = 5'd20;
    #1;
    checkOutput("preRstCount", 64'(count), 64'd2);
    checkOutput("preRstHit1", 64'(hit_1), 64'(FWD));
    wb_busy = 1'b0;
    rstn = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midRstWe", 64'(rf_we), 64'd0);
    checkOutput("midRstWaddr", 64'(rf_waddr), 64'd0);
    checkOutput("midRstWdata", 64'(rf_wdata), 64'd0);
    checkOutput("midRstCount", 64'(count), 64'd0);
    checkOutput("midRstReady", 64'(in_ready), 64'd1);
    checkOutput("midRstHit1", 64'(hit_1), 64'd0);
    checkOutput("midRstHitData1", 64'(hit_data_1), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("postRstWe", 64'(rf_we), 64'd0);
    end

    checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_write_buffer.md
WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered write entries; SHALL be a power of two, at least 2.
REQ-002 Parameter XLEN, default 32, data width of each write.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rstn  input  1  reset; it SHALL be asynchronous and active-low.
REQ-005 Port in_valid  input  1  producer presents a write request.
REQ-006 Port in_ready  output  1  buffer can accept a request this cycle.
REQ-007 Port in_rd  input  5  destination register index.
REQ-008 Port in_data  input  XLEN  destination register value.
REQ-009 Port wb_busy  input  1  register-file write port is taken by the main pipeline this cycle; no drain.
REQ-010 Port rf_we  output  1  write enable to the register-file write port.
REQ-011 Port rf_waddr  output  5  write address to the register-file write port.
REQ-012 Port rf_wdata  output  XLEN  write data to the register-file write port.
REQ-013 Port q_addr_1, q_addr_2  input  5 each  forwarding lookup indices, matching the two register-file read ports.
REQ-014 Port hit_1, hit_2  output  1 each  a pending buffered write matches the lookup index.
REQ-015 Port hit_data_1, hit_data_2  output  XLEN each  value of the youngest matching pending write.
REQ-016 Port count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 Storage SHALL be a FIFO of DEPTH entries {rd, data}, with read and write pointers wrapping modulo DEPTH.
REQ-018 in_ready SHALL be 1 exactly when count < DEPTH; it SHALL NOT depend on a same-cycle drain.
REQ-019 Accept: in_valid && in_ready && in_rd != 0 SHALL enqueue at the rising edge; count increments by 1 unless a drain occurs in the same cycle.
REQ-020 A handshake with in_rd == 0 SHALL complete (is accepted) but SHALL NOT be stored; count is unchanged by it.
REQ-021 Drain: rf_we SHALL be combinationally (count != 0) && !wb_busy; rf_waddr and rf_wdata SHALL show the head entry whenever count != 0, and 0 when empty.
REQ-022 When rf_we is 1, the head entry SHALL be popped at the rising edge.
REQ-023 There SHALL be no same-cycle bypass: an entry accepted at edge N SHALL appear on rf_we no earlier than the cycle after edge N (minimum latency 1 cycle).
REQ-024 Simultaneous accept and drain SHALL leave count unchanged, including when count == DEPTH-1 and when count == 1.
REQ-025 Order SHALL be preserved: writes reach the register file in acceptance order, including writes to the same rd.
REQ-026 Lookup: hit_k SHALL be 1 when q_addr_k != 0 and any valid entry, including the head being drained this cycle, has rd == q_addr_k.
REQ-027 On a hit, hit_data_k SHALL be the data of the youngest matching entry; on a miss, hit_data_k SHALL be 0.
REQ-028 Lookup outputs SHALL be combinational from current state and SHALL NOT reflect the request being accepted in the same cycle.
REQ-029 wb_busy held high SHALL stall the drain indefinitely with no loss of entries; in_ready falls once count reaches DEPTH.

Reset
REQ-030 While rstn == 0, all entries SHALL be invalidated, both pointers and count SHALL be 0, and in_ready SHALL be 1.
REQ-031 While rstn == 0, rf_we, rf_waddr, rf_wdata, hit_1, hit_2, hit_data_1 and hit_data_2 SHALL all be 0.
REQ-032 Reset asserted mid-operation SHALL discard all pending writes; none SHALL reach the register file after reset.

Configuration
REQ-033 Macro WB_WRITE_BUFFER_FORWARD_EN defined: REQ-026 to REQ-028 SHALL apply.
REQ-034 Macro WB_WRITE_BUFFER_FORWARD_EN undefined: hit_1, hit_2, hit_data_1 and hit_data_2 SHALL be constant 0, the match logic SHALL be absent, and all ports SHALL remain present.

Verification
REQ-035 Reset, then push {rd=10, data=21} with wb_busy=0 -> next cycle rf_we=1, rf_waddr=10, rf_wdata=21; the following cycle count=0.
REQ-036 wb_busy=1, push 4 entries (rd 1..4) -> in_ready=0 and count=4 with no rf_we; release wb_busy -> writes to rd 1,2,3,4 on 4 consecutive cycles.
REQ-037 Push {rd=5, data=7} then {rd=5, data=9} while stalled, q_addr_1=5 -> hit_1=1 and hit_data_1=9; q_addr_2=0 -> hit_2=0.
REQ-038 Push with in_rd=0 -> handshake completes, count remains 0, rf_we never asserts.
REQ-039 count=3, simultaneous push and drain -> count stays 3; pointers wrap past DEPTH-1 with order preserved over 10 pushes.
REQ-040 rstn driven low with count=2 -> all outputs 0 immediately without a clock edge; after release, rf_we=0 and no stale write is issued.
